// File: rtl/acp_tx_pkg.sv
// Shared types and constants for the ACP write-channel sample source.
package acp_tx_pkg;

  localparam int BURST_LEN_DFLT = 16;
  localparam int BURST_BYTES    = BURST_LEN_DFLT * 8;
  localparam int AWID_W         = 3;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_e;

  // Next ring offset plus a flag saying the ring wrapped back to zero
  typedef struct packed {
    logic [31:0] off;
    logic        wrap;
  } ring_t;

  function automatic ring_t ring_next(input logic [31:0] off,
                                      input logic [31:0] size,
                                      input logic [31:0] step);
    ring_t r;
    r.off  = off + step;
    r.wrap = (r.off >= size);
    if (r.wrap) r.off = '0;
    return r;
  endfunction

endpackage

// File: rtl/acp_tx_fifo.sv
// Synchronous FIFO with registered read data, occupancy count and flush.
// A write while full is accepted only if a read happens on the same edge.
module acp_tx_fifo #(
  parameter int AW = 6,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam int            DEPTH    = 1 << AW;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [DW-1:0] rd_q, rd_d;
  logic          do_wr, do_rd;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign count   = cnt_q;
  assign rd_data = rd_q;

  // Pointer, occupancy and read-register next state
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    rd_d  = rd_q;
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_wr) wp_d = wp_q + 1'b1;
      if (do_rd) begin
        rp_d = rp_q + 1'b1;
        rd_d = mem_q[rp_q];
      end
      case ({do_wr, do_rd})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      rd_q  <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      rd_q  <= rd_d;
    end
  end

  // Storage array, no reset needed since count gates every read
  always_ff @(posedge clk) begin
    if (do_wr && !flush) mem_q[wp_q] <= wr_data;
  end

endmodule

// File: rtl/acp_tx_source.sv
// Packs 32-bit samples into 64-bit words, buffers them, and writes fixed
// bursts into a DDR ring buffer over the ACP write channel.
module acp_tx_source
  import acp_tx_pkg::*;
#(
  parameter int BURST_LEN = BURST_BYTES / 8,
  parameter int FIFO_AW   = 6,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_en,
  input  logic [31:0]       cfg_base,
  input  logic [31:0]       cfg_size,
  input  logic [31:0]       din,
  input  logic              din_vld,
  output logic              acp0_tx_en,
  input  logic              acp0_tx_rdy,
  output logic [ADDR_W-1:0] acp0_tx_awaddr,
  output logic [AWID_W-1:0] acp0_tx_awid,
  input  logic              acp0_tx_wdreq,
  output logic [63:0]       acp0_tx_wdata,
  output logic [31:0]       wr_off,
  output logic [31:0]       burst_cnt,
  output logic              ovf,
  output logic              busy,
  output logic              wrap_irq
);

  localparam int               BW      = $clog2(BURST_LEN) + 1;
  localparam logic [BW-1:0]    BL_BEAT = BW'(BURST_LEN);
  localparam logic [FIFO_AW:0] BL_CNT  = (FIFO_AW+1)'(BURST_LEN);

  state_e              state_q, state_d;
  logic                en_prev_q, en_prev_d;
  logic [31:0]         base_q, base_d, size_q, size_d;
  logic                half_q, half_d;
  logic [31:0]         lo_q, lo_d;
  logic                pack_vld_q, pack_vld_d;
  logic [63:0]         pack_q, pack_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic                tx_en_q, tx_en_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [AWID_W-1:0]   awid_q, awid_d;
  logic [31:0]         wr_off_q, wr_off_d;
  logic [31:0]         burst_cnt_q, burst_cnt_d;
  logic                ovf_q, ovf_d;
  logic                busy_q, busy_d;
  logic                wrap_q, wrap_d;
  ring_t               ring;

  logic                flush, pop;
  logic                fifo_full, fifo_empty;
  logic [FIFO_AW:0]    fifo_count;

  // Disabled and idle: discard everything buffered so a re-enable starts clean
  assign flush = !cfg_en && (state_q == IDLE);
  assign pop   = (state_q == DATA) && acp0_tx_wdreq && (beat_q < BL_BEAT) && !fifo_empty;

  acp_tx_fifo #(.AW(FIFO_AW), .DW(64)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .wr_en   (pack_vld_q),
    .wr_data (pack_q),
    .rd_en   (pop),
    .rd_data (acp0_tx_wdata),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Sample packer: first sample fills the low half, second completes the word
  always_comb begin
    half_d     = half_q;
    lo_d       = lo_q;
    pack_d     = pack_q;
    pack_vld_d = 1'b0;
    if (flush) begin
      half_d = 1'b0;
      lo_d   = '0;
      pack_d = '0;
    end else if (cfg_en && din_vld) begin
      if (!half_q) begin
        lo_d   = din;
        half_d = 1'b1;
      end else begin
        pack_d     = {din, lo_q};
        pack_vld_d = 1'b1;
        half_d     = 1'b0;
      end
    end
  end

  // Ring config latched on enable rising edge; sticky overflow on dropped push
  always_comb begin
    en_prev_d = cfg_en;
    base_d    = base_q;
    size_d    = size_q;
    if (cfg_en && !en_prev_q) begin
      base_d = cfg_base;
      size_d = cfg_size;
    end
    ovf_d = ovf_q;
    if (flush)                                 ovf_d = 1'b0;
    else if (pack_vld_q && fifo_full && !pop)  ovf_d = 1'b1;
  end

  // Burst FSM with registered channel outputs and ring bookkeeping
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    tx_en_d     = tx_en_q;
    awaddr_d    = awaddr_q;
    awid_d      = awid_q;
    wr_off_d    = wr_off_q;
    burst_cnt_d = burst_cnt_q;
    wrap_d      = 1'b0;
    ring        = ring_next(wr_off_q, size_q, 32'(BURST_LEN * 8));
    case (state_q)
      IDLE: begin
        if (cfg_en && fifo_count >= BL_CNT) begin
          state_d  = ADDR;
          tx_en_d  = 1'b1;
          awaddr_d = ADDR_W'(base_q + wr_off_q);
        end
      end
      ADDR: begin
        if (acp0_tx_rdy) begin
          state_d = DATA;
          tx_en_d = 1'b0;
          beat_d  = '0;
        end
      end
      DATA: begin
        if (pop) beat_d = beat_q + 1'b1;
        // Last beat's data went out on the previous edge; close the burst
        if (beat_q == BL_BEAT) begin
          state_d     = DONE;
          wr_off_d    = ring.off;
          wrap_d      = ring.wrap;
          burst_cnt_d = burst_cnt_q + 32'd1;
          awid_d      = awid_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) wr_off_d = '0;
    busy_d = (state_d != IDLE);
  end

  // All state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      en_prev_q   <= 1'b0;
      base_q      <= '0;
      size_q      <= '0;
      half_q      <= 1'b0;
      lo_q        <= '0;
      pack_vld_q  <= 1'b0;
      pack_q      <= '0;
      beat_q      <= '0;
      tx_en_q     <= 1'b0;
      awaddr_q    <= '0;
      awid_q      <= '0;
      wr_off_q    <= '0;
      burst_cnt_q <= '0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_prev_q   <= en_prev_d;
      base_q      <= base_d;
      size_q      <= size_d;
      half_q      <= half_d;
      lo_q        <= lo_d;
      pack_vld_q  <= pack_vld_d;
      pack_q      <= pack_d;
      beat_q      <= beat_d;
      tx_en_q     <= tx_en_d;
      awaddr_q    <= awaddr_d;
      awid_q      <= awid_d;
      wr_off_q    <= wr_off_d;
      burst_cnt_q <= burst_cnt_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      wrap_q      <= wrap_d;
    end
  end

  assign acp0_tx_en     = tx_en_q;
  assign acp0_tx_awaddr = awaddr_q;
  assign acp0_tx_awid   = awid_q;
  assign wr_off         = wr_off_q;
  assign burst_cnt      = burst_cnt_q;
  assign ovf            = ovf_q;
  assign busy           = busy_q;
  assign wrap_irq       = wrap_q;

endmodule

// File: tb/tb_acp_tx_source.sv
// Directed/randomized bench for acp_tx_source with a queue-based ring model.
module tb_acp_tx_source;

  logic        clk = 1'b0;
  logic        rst, cfg_en, din_vld, rdy, wdreq;
  logic [31:0] cfg_base, cfg_size, din;
  logic        en, ovf, busy, wrap_irq;
  logic [31:0] awaddr, wr_off, burst_cnt;
  logic [2:0]  awid;
  logic [63:0] wdata;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [63:0] mq[$];
  bit          m_half, m_ovf;
  logic [31:0] m_lo, m_base, m_size, m_off, m_cnt;
  int          m_awid;
  logic [63:0] last_wd;

  always #4 clk = ~clk;

  acp_tx_source dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_base(cfg_base), .cfg_size(cfg_size),
    .din(din), .din_vld(din_vld), .acp0_tx_en(en), .acp0_tx_rdy(rdy),
    .acp0_tx_awaddr(awaddr), .acp0_tx_awid(awid), .acp0_tx_wdreq(wdreq),
    .acp0_tx_wdata(wdata), .wr_off(wr_off), .burst_cnt(burst_cnt), .ovf(ovf),
    .busy(busy), .wrap_irq(wrap_irq)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_half = 0; m_ovf = 0; m_lo = '0;
    m_off = '0; m_cnt = '0; m_awid = 0; last_wd = '0;
  endtask

  task automatic model_sample(input logic [31:0] s);
    if (!m_half) begin
      m_lo = s; m_half = 1;
    end else begin
      m_half = 0;
      if (mq.size() < 64) mq.push_back({s, m_lo});
      else m_ovf = 1;
    end
  endtask

  task automatic check_reset_vals(input string p);
    chk({p, "_en"}, en, 0);         chk({p, "_awaddr"}, awaddr, 0);
    chk({p, "_awid"}, awid, 0);     chk({p, "_wdata"}, wdata, 0);
    chk({p, "_wr_off"}, wr_off, 0); chk({p, "_burst_cnt"}, burst_cnt, 0);
    chk({p, "_ovf"}, ovf, 0);       chk({p, "_busy"}, busy, 0);
    chk({p, "_wrap"}, wrap_irq, 0);
  endtask

  task automatic reset_dut();
    rst = 1; cfg_en = 0; din_vld = 0; rdy = 0; wdreq = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic enable(input logic [31:0] base, input logic [31:0] size);
    cfg_base = base; cfg_size = size; cfg_en = 1;
    m_base = base; m_size = size;
    @(negedge clk);
  endtask

  task automatic feed(input int n, input int max_gap, input bit seq, input logic [31:0] start);
    logic [31:0] s;
    for (int i = 0; i < n; i++) begin
      s = seq ? start + 32'(i) : $urandom;
      din = s; din_vld = 1;
      if (cfg_en) model_sample(s);
      @(negedge clk);
      din_vld = 0;
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  // Acts as the PS side for one burst; checks address phase, beats and DONE
  task automatic run_burst(input int rdy_dly, input int max_gap, input int drop_at, input int rst_at);
    int w;
    bit wrap;
    logic [63:0] exp;
    w = 0;
    while (!en && w < 300) begin @(negedge clk); w++; end
    chk("en_wait", en, 1);
    if (!en) return;
    chk("awaddr", awaddr, m_base + m_off);
    chk("awid", awid, m_awid);
    for (int d = 0; d < rdy_dly; d++) begin
      wdreq = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("en_hold", en, 1);
      chk("awaddr_hold", awaddr, m_base + m_off);
      chk("wdata_addr_phase", wdata, last_wd);
    end
    wdreq = 0; rdy = 1;
    @(negedge clk);
    rdy = 0;
    chk("en_drop", en, 0);
    for (int k = 0; k < 16; k++) begin
      repeat ($urandom_range(0, max_gap)) begin
        wdreq = 0;
        @(negedge clk);
        chk("wdata_gap", wdata, last_wd);
      end
      wdreq = 1;
      @(negedge clk);
      wdreq = 0;
      exp = (mq.size() > 0) ? mq.pop_front() : 64'd0;
      chk("beat", wdata, exp);
      last_wd = exp;
      if (k == drop_at) cfg_en = 0;
      if (k == rst_at) begin
        rst = 1;
        @(negedge clk);
        rst = 0;
        check_reset_vals("rst_mid");
        model_reset();
        return;
      end
    end
    chk("busy_data", busy, 1);
    chk("wrap_early", wrap_irq, 0);
    wdreq = 1;  // 17th request must be ignored
    @(negedge clk);
    wdreq = 0;
    m_off = m_off + 32'd128;
    wrap  = (m_off >= m_size);
    if (wrap) m_off = '0;
    m_cnt++;
    m_awid = (m_awid + 1) % 8;
    chk("wdata_extra", wdata, last_wd);
    chk("wrap_irq", wrap_irq, wrap);
    chk("wr_off", wr_off, m_off);
    chk("burst_cnt", burst_cnt, m_cnt);
    chk("awid_next", awid, m_awid);
    chk("busy_done", busy, 1);
    @(negedge clk);
    chk("wrap_after", wrap_irq, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    cfg_base = '0; cfg_size = '0; din = '0;
    reset_dut();
    check_reset_vals("reset");

    // Samples while disabled are ignored
    feed(4, 0, 1, 32'd100);

    // Basic burst: samples 0..31
    enable(32'h1000_0000, 32'h400);
    feed(32, 0, 1, 32'd0);
    run_burst(0, 0, -1, -1);
    chk("basic_wr_off", wr_off, 32'h80);
    chk("basic_cnt", burst_cnt, 1);

    // Wrap from a fresh state: offsets 0, 0x80, 0
    reset_dut();
    enable(32'h1000_0000, 32'h100);
    feed(96, 0, 0, 0);
    for (int b = 0; b < 3; b++) run_burst(0, 0, -1, -1);

    // Handshake stalls
    feed(64, 2, 0, 0);
    run_burst(5, 3, -1, -1);
    run_burst(5, 3, -1, -1);

    // Overflow: 70 words into a 64-deep FIFO
    feed(140, 0, 0, 0);
    chk("ovf_set", ovf, m_ovf);
    chk("fifo_full_count", dut.u_fifo.count, 64);
    for (int b = 0; b < 4; b++) run_burst(0, 1, -1, -1);
    chk("ovf_sticky", ovf, 1);

    // Disable after the 5th wdreq: burst finishes, then flush
    feed(48, 0, 0, 0);
    run_burst(2, 1, 4, -1);
    @(negedge clk);
    chk("flush_wr_off", wr_off, 0);
    chk("flush_ovf", ovf, 0);
    chk("flush_busy", busy, 0);
    chk("flush_empty", dut.u_fifo.empty, 1);
    mq.delete(); m_half = 0; m_off = '0; m_ovf = 0;

    // 15 words must not start a burst; the 16th does
    enable(32'h2000_0000, 32'h200);
    feed(30, 1, 0, 0);
    repeat (4) @(negedge clk);
    chk("no_burst_15", en, 0);
    feed(2, 0, 0, 0);
    run_burst(0, 0, -1, -1);

    // Reset during DATA at beat 8, then requests must not pop
    feed(32, 0, 0, 0);
    run_burst(0, 1, -1, 7);
    for (int i = 0; i < 3; i++) begin
      wdreq = 1;
      @(negedge clk);
      wdreq = 0;
      chk("post_rst_wdata", wdata, 0);
      chk("post_rst_en", en, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
